fifo_ram_arbiter: RTL and testbench
===================================

Name: fifo_ram_arbiter

Overview:
Controller that shares one FIFOram instance between two producer ports and one consumer port. It arbitrates producer writes round-robin, tracks occupancy to generate full/empty, and drives the FIFOram write/read strobes and data-in. It also realigns FIFOram read data to a consumer valid strobe. It sits directly in front of FIFOram; FIFOram itself carries no flags and no overflow protection.

Parameters:
DW, 16, data width; matches the FIFOram word.
DEPTH, 8, FIFOram word capacity.
CNT_W, 4, occupancy counter width; must hold DEPTH.
RD_LAT, 1, cycles from a fifo_read strobe to valid fifo_dout.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
p0_req  in  1  producer 0 write request (level)
p0_data  in  DW  producer 0 write word
p0_ack  out  1  producer 0 word accepted (1-cycle pulse)
p1_req  in  1  producer 1 write request
p1_data  in  DW  producer 1 write word
p1_ack  out  1  producer 1 word accepted
c_req  in  1  consumer read request (level; one word per accepted cycle)
c_data  out  DW  consumer read word
c_valid  out  1  c_data valid (1-cycle pulse per word)
fifo_reset  out  1  active-high reset to FIFOram; equals ~reset
fifo_write  out  1  FIFOram write strobe
fifo_read  out  1  FIFOram read strobe
fifo_din  out  DW  FIFOram write data
fifo_dout  in  DW  FIFOram read data
count  out  CNT_W  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (reset=0 at a clk edge): on that edge, clear all registered outputs: acks, fifo_write, fifo_read, fifo_din=0, c_valid, c_data=0, count=0. The round-robin pointer goes to port 0. In-flight reads are discarded. Reset mid-operation takes effect on the next edge; no partial transfer completes. fifo_reset is combinational ~reset.
- Outputs are registered except fifo_reset, full and empty, which decode count.
- Write eligibility: port n is eligible when pn_req=1 and pn_ack=0 in the same cycle. Masking ack prevents double-accepting a held word.
- Write grant: a grant occurs when any port is eligible and count < DEPTH. With one eligible port, grant it. With both eligible, grant the port the pointer favours; the pointer then moves to the other port. The pointer moves only on a contested grant.
- Grant at edge N: fifo_write=1, fifo_din=granted data and pn_ack=1 during cycle N+1, all for one cycle.
- Producer contract: hold data with req until ack is seen. In the cycle after ack, drop req or present the next word.
- Read issue: occurs when c_req=1 and count > 0. fifo_read=1 for one cycle; back-to-back reads are allowed while count > 0.
- Read return: the shift pipeline is RD_LAT deep. c_valid=1 and c_data=fifo_dout are registered RD_LAT+1 cycles after the c_req edge.
- Count update, each edge: count += write_granted − read_issued. Simultaneous write and read leave count unchanged.
- Full: when count == DEPTH, no write is granted, even if a read issues in the same cycle. Producers stall with req high and no ack.
- Empty: when count == 0, no read is issued, even if a write is granted in the same cycle.
- Overflow and underflow of FIFOram are impossible by construction. Data order is FIFO across both producers in grant order.

Decomposition:
- Package fifo_ctrl_pkg: DW, DEPTH, CNT_W and RD_LAT defaults, plus port index constants PORT0=0 and PORT1=1.
- Sub-module rr_arb2: two-request round-robin arbiter. Inputs: eligible vector and advance enable. Outputs: one-hot grant and pointer state. The synchronous active-low reset sets pointer=0.

Test Plan:
1. Reset, then p0 writes AAAA, BBBB, CCCC (holding req until ack), then c_req for 3 cycles -> fifo_write pulses with din AAAA/BBBB/CCCC; count reaches 3, then 0; c_valid returns AAAA, BBBB, CCCC in order; empty=1 at end.
2. p0 and p1 both held high with 1111/2222 at pointer=0 -> grants p0 then p1; ack order p0, p1; stored order 1111 then 2222; pointer back at 0 after the second contested grant.
3. Fill to DEPTH=8 from p1, then p0 requests 9999 -> full=1, no p0_ack, no fifo_write. One read issued -> next cycle 9999 is accepted; count stays 8.
4. Empty FIFO with c_req=1 and a p0 write of 5A5A in the same cycle -> no fifo_read that cycle. The next cycle a read issues; c_valid with 5A5A RD_LAT+1 cycles later.
5. count=4 and a read in flight, then reset=0 for one edge -> count=0, c_valid=0, acks=0, fifo_reset=1 while reset low. No stale c_valid after release.
6. Simultaneous write and read at count=3 -> count stays 3; both fifo_write and fifo_read pulse in the same cycle.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared defaults and port indices for the FIFOram front-end controller.
// Rev 1.0
`default_nettype none

package fifo_ctrl_pkg;
    localparam int DW_DEFAULT     = 16;
    localparam int DEPTH_DEFAULT  = 8;
    localparam int CNT_W_DEFAULT  = 4;
    localparam int RD_LAT_DEFAULT = 1;

    localparam logic [0:0] PORT0 = 1'b0;
    localparam logic [0:0] PORT1 = 1'b1;

    typedef logic [1:0] port_vec_t;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; pointer flips only on a contested, accepted grant.
// Rev 1.0
`default_nettype none

module rr_arb2
    import fifo_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  port_vec_t eligible,
    input  logic      advance,
    output port_vec_t grant,
    output logic      ptr
);

    always_comb begin
        grant = eligible;
        if (&eligible) begin
            grant = (ptr == PORT1) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= PORT0;
        end else if (advance && (&eligible)) begin
            ptr <= ~ptr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_ram_arbiter.sv
// fifo_ram_arbiter: shares one flagless FIFOram between two producers and one consumer.
// Rev 1.0
`default_nettype none

module fifo_ram_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p0_req,
    input  logic [DW-1:0]    p0_data,
    output logic             p0_ack,
    input  logic             p1_req,
    input  logic [DW-1:0]    p1_data,
    output logic             p1_ack,
    input  logic             c_req,
    output logic [DW-1:0]    c_data,
    output logic             c_valid,
    output logic             fifo_reset,
    output logic             fifo_write,
    output logic             fifo_read,
    output logic [DW-1:0]    fifo_din,
    input  logic [DW-1:0]    fifo_dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    port_vec_t          eligible;
    port_vec_t          grant;
    logic               ptr;
    logic               room;
    logic               wr_grant;
    logic               wr_sel;
    logic               rd_issue;
    logic [RD_LAT-1:0]  rd_pipe;

    // A port whose ack is showing still holds the word just taken; skip it this cycle.
    assign eligible = {p1_req & ~p1_ack, p0_req & ~p0_ack};
    assign room     = (count < CNT_W'(DEPTH));
    assign wr_grant = (|eligible) && room;
    assign wr_sel   = (&eligible) ? ptr : eligible[PORT1];
    assign rd_issue = c_req && (count != '0);

    assign fifo_reset = ~reset;
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .eligible (eligible),
        .advance  (room),
        .grant    (grant),
        .ptr      (ptr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
            fifo_din   <= '0;
            c_valid    <= 1'b0;
            c_data     <= '0;
            count      <= '0;
        end else begin
            p0_ack     <= wr_grant && grant[PORT0];
            p1_ack     <= wr_grant && grant[PORT1];
            fifo_write <= wr_grant;
            if (wr_grant) begin
                fifo_din <= (wr_sel == PORT1) ? p1_data : p0_data;
            end
            fifo_read  <= rd_issue;
            c_valid    <= rd_pipe[RD_LAT-1];
            if (rd_pipe[RD_LAT-1]) begin
                c_data <= fifo_dout;
            end
            count      <= count + CNT_W'(wr_grant) - CNT_W'(rd_issue);
        end
    end

    // Tracks each read strobe until FIFOram has had RD_LAT cycles to present its word.
    generate
        if (RD_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= fifo_read;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_pipe <= '0;
                end else begin
                    rd_pipe <= {rd_pipe[RD_LAT-2:0], fifo_read};
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_ram_arbiter.sv
// tb_fifo_ram_arbiter: directed scenarios plus randomized traffic against a queue-based reference.
// Rev 1.0
`default_nettype none

module tb_fifo_ram_arbiter;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             p0_req = 1'b0, p1_req = 1'b0, c_req = 1'b0;
    logic [DW-1:0]    p0_data = '0, p1_data = '0;
    logic             p0_ack, p1_ack, c_valid, fifo_reset, fifo_write, fifo_read, full, empty;
    logic [DW-1:0]    c_data, fifo_din;
    logic [DW-1:0]    fifo_dout = '0;
    logic [CNT_W-1:0] count;

    int checks = 0;
    int failures = 0;

    fifo_ram_arbiter #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_data(p0_data), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_data(p1_data), .p1_ack(p1_ack),
        .c_req(c_req), .c_data(c_data), .c_valid(c_valid),
        .fifo_reset(fifo_reset), .fifo_write(fifo_write), .fifo_read(fifo_read),
        .fifo_din(fifo_din), .fifo_dout(fifo_dout),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // FIFOram stand-in: flagless circular store with one-cycle registered read.
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [2:0]    wp = '0, rp = '0;
    always @(posedge clk) begin
        if (fifo_reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (fifo_write) begin
                mem[wp] <= fifo_din;
                wp <= wp + 3'd1;
            end
            if (fifo_read) begin
                fifo_dout <= mem[rp];
                rp <= rp + 3'd1;
            end
        end
    end

    // Reference: stored words as a queue, round-robin favour as a bit, returns as a 2-deep delay.
    logic [DW-1:0] m_q[$];
    logic          m_ptr = 1'b0;
    logic          e_p0_ack = 1'b0, e_p1_ack = 1'b0, e_fw = 1'b0, e_fr = 1'b0, e_cv = 1'b0;
    logic [DW-1:0] e_din = '0, e_cd = '0;
    logic          r1v = 1'b0, r2v = 1'b0;
    logic [DW-1:0] r1d = '0, r2d = '0;
    logic [DW-1:0] got[$];

    task automatic tick();
        logic el0, el1, wg, rd, gs;
        logic [DW-1:0] wd;
        el0 = p0_req && !e_p0_ack;
        el1 = p1_req && !e_p1_ack;
        wg  = (el0 || el1) && (m_q.size() < DEPTH);
        gs  = (el0 && el1) ? m_ptr : el1;
        wd  = gs ? p1_data : p0_data;
        rd  = c_req && (m_q.size() > 0);
        @(posedge clk);
        if (!reset) begin
            m_q.delete();
            m_ptr = 1'b0; e_p0_ack = 1'b0; e_p1_ack = 1'b0; e_fw = 1'b0; e_fr = 1'b0;
            e_cv = 1'b0; e_din = '0; e_cd = '0; r1v = 1'b0; r2v = 1'b0;
        end else begin
            e_cv = r2v;
            if (r2v) e_cd = r2d;
            r2v = r1v; r2d = r1d;
            r1v = rd;
            if (rd) r1d = m_q.pop_front();
            if (wg) begin
                m_q.push_back(wd);
                e_din = wd;
                if (el0 && el1) m_ptr = !m_ptr;
            end
            e_fw = wg; e_fr = rd;
            e_p0_ack = wg && !gs;
            e_p1_ack = wg && gs;
        end
        #1;
    endtask

    task automatic do_reset();
        p0_req = 0; p1_req = 0; c_req = 0; reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic fill(input int port, input int n, input logic [DW-1:0] base);
        logic ack;
        for (int k = 0; k < n; k++) begin
            if (port == 0) begin p0_req = 1; p0_data = base + DW'(k); end
            else begin p1_req = 1; p1_data = base + DW'(k); end
            ack = 0;
            for (int i = 0; i < 6 && !ack; i++) begin
                tick();
                ack = (port == 0) ? p0_ack : p1_ack;
            end
        end
        p0_req = 0; p1_req = 0;
        tick();
    endtask

    task automatic drain(input int cycles);
        got.delete();
        c_req = 1;
        repeat (cycles) begin
            tick();
            if (c_valid === 1'b1) got.push_back(c_data);
        end
        c_req = 0;
    endtask

    task automatic test_reset();
        reset = 0; p0_req = 0; p1_req = 0; c_req = 0;
        tick(); tick();
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
        checks++; if (fifo_reset !== 1'b1) begin failures++; $display("FAIL reset_fifo_reset got=%b exp=1", fifo_reset); end
        checks++; if ({p0_ack, p1_ack, c_valid, fifo_write, fifo_read} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=00000", {p0_ack, p1_ack, c_valid, fifo_write, fifo_read}); end
        checks++; if (c_data !== 16'h0 || fifo_din !== 16'h0) begin failures++; $display("FAIL reset_data c_data=%h fifo_din=%h exp 0", c_data, fifo_din); end
        reset = 1; #1;
        checks++; if (fifo_reset !== 1'b0) begin failures++; $display("FAIL release_fifo_reset got=%b exp=0", fifo_reset); end
    endtask

    task automatic test_single_producer();
        logic [DW-1:0] words [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        logic ack;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            p0_req = 1; p0_data = words[k]; ack = 0;
            for (int i = 0; i < 6 && !ack; i++) begin tick(); ack = p0_ack; end
            checks++; if (!ack || fifo_write !== 1'b1 || fifo_din !== words[k]) begin failures++; $display("FAIL p0_write%0d ack=%b fw=%b din=%h exp 1/1/%h", k, ack, fifo_write, fifo_din, words[k]); end
        end
        p0_req = 0;
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL p0_count got=%0d exp=3", count); end
        drain(8);
        checks++; if (got.size() != 3 || got[0] !== 16'hAAAA || got[1] !== 16'hBBBB || got[2] !== 16'hCCCC) begin failures++; $display("FAIL p0_readback got=%p exp AAAA BBBB CCCC", got); end
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL p0_empty count=%0d empty=%b exp 0/1", count, empty); end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] a0 [3] = '{16'h1111, 16'h3333, 16'h5555};
        logic [DW-1:0] a1 [3] = '{16'h2222, 16'h4444, 16'h6666};
        logic [1:0] first_exp [3] = '{2'b01, 2'b10, 2'b01};
        logic [1:0] first;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            p0_req = 1; p1_req = 1; p0_data = a0[r]; p1_data = a1[r]; first = 2'b00;
            for (int i = 0; i < 8 && (p0_req || p1_req); i++) begin
                tick();
                if (first == 2'b00) first = {p1_ack, p0_ack};
                if (p0_ack) p0_req = 0;
                if (p1_ack) p1_req = 0;
            end
            checks++; if (first !== first_exp[r]) begin failures++; $display("FAIL rr_round%0d first_ack got=%b exp=%b", r, first, first_exp[r]); end
            tick();
        end
        drain(12);
        checks++; if (got.size() != 6 || got[0] !== 16'h1111 || got[1] !== 16'h2222 || got[2] !== 16'h4444 || got[3] !== 16'h3333 || got[4] !== 16'h5555 || got[5] !== 16'h6666) begin failures++; $display("FAIL rr_order got=%p exp 1111 2222 4444 3333 5555 6666", got); end
    endtask

    task automatic test_full();
        logic stalled;
        do_reset();
        fill(1, DEPTH, 16'h1000);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL full_flag full=%b count=%0d exp 1/8", full, count); end
        p0_req = 1; p0_data = 16'h9999; stalled = 1;
        repeat (3) begin tick(); if (p0_ack !== 1'b0 || fifo_write !== 1'b0) stalled = 0; end
        checks++; if (!stalled) begin failures++; $display("FAIL full_stall ack/write seen while full exp none"); end
        c_req = 1; tick(); c_req = 0;
        checks++; if (fifo_read !== 1'b1 || p0_ack !== 1'b0 || count !== 4'd7) begin failures++; $display("FAIL full_read fr=%b ack=%b count=%0d exp 1/0/7", fifo_read, p0_ack, count); end
        tick(); p0_req = 0;
        checks++; if (p0_ack !== 1'b1 || fifo_write !== 1'b1 || fifo_din !== 16'h9999 || count !== 4'd8) begin failures++; $display("FAIL full_refill ack=%b fw=%b din=%h count=%0d exp 1/1/9999/8", p0_ack, fifo_write, fifo_din, count); end
        drain(14);
        checks++; if (got.size() != 9 || got[0] !== 16'h1000 || got[7] !== 16'h1007 || got[8] !== 16'h9999) begin failures++; $display("FAIL full_readback got=%p exp 1000..1007 9999", got); end
    endtask

    task automatic test_empty_bypass();
        do_reset();
        p0_req = 1; p0_data = 16'h5A5A; c_req = 1;
        tick(); p0_req = 0;
        checks++; if (p0_ack !== 1'b1 || fifo_read !== 1'b0 || count !== 4'd1) begin failures++; $display("FAIL empty_noread ack=%b fr=%b count=%0d exp 1/0/1", p0_ack, fifo_read, count); end
        tick(); c_req = 0;
        checks++; if (fifo_read !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL empty_read fr=%b count=%0d exp 1/0", fifo_read, count); end
        tick();
        checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL empty_early_valid got=%b exp=0", c_valid); end
        tick();
        checks++; if (c_valid !== 1'b1 || c_data !== 16'h5A5A) begin failures++; $display("FAIL empty_return valid=%b data=%h exp 1/5a5a", c_valid, c_data); end
    endtask

    task automatic test_reset_midflight();
        logic stale;
        do_reset();
        fill(0, 5, 16'h7000);
        c_req = 1; tick(); c_req = 0;
        checks++; if (count !== 4'd4 || fifo_read !== 1'b1) begin failures++; $display("FAIL mid_setup count=%0d fr=%b exp 4/1", count, fifo_read); end
        p0_req = 1; p0_data = 16'h7777; reset = 0; #1;
        checks++; if (fifo_reset !== 1'b1) begin failures++; $display("FAIL mid_fifo_reset got=%b exp=1", fifo_reset); end
        tick();
        checks++; if (count !== 4'd0 || c_valid !== 1'b0 || p0_ack !== 1'b0 || fifo_write !== 1'b0 || fifo_read !== 1'b0) begin failures++; $display("FAIL mid_cleared count=%0d cv=%b ack=%b fw=%b fr=%b exp all 0", count, c_valid, p0_ack, fifo_write, fifo_read); end
        p0_req = 0; reset = 1; stale = 0;
        repeat (4) begin tick(); if (c_valid !== 1'b0) stale = 1; end
        checks++; if (stale || empty !== 1'b1) begin failures++; $display("FAIL mid_stale stale_valid=%b empty=%b exp 0/1", stale, empty); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fill(0, 3, 16'h3000);
        p0_req = 1; p0_data = 16'h3333; c_req = 1;
        tick(); p0_req = 0; c_req = 0;
        checks++; if (fifo_write !== 1'b1 || fifo_read !== 1'b1 || count !== 4'd3) begin failures++; $display("FAIL simul fw=%b fr=%b count=%0d exp 1/1/3", fifo_write, fifo_read, count); end
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(79) != 0);
            c_req = $urandom_range(1);
            tick();
            checks++;
            if (count !== CNT_W'(m_q.size()) || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0) ||
                p0_ack !== e_p0_ack || p1_ack !== e_p1_ack || fifo_write !== e_fw || fifo_read !== e_fr ||
                c_valid !== e_cv || (e_cv && c_data !== e_cd) || (e_fw && fifo_din !== e_din)) begin
                failures++;
                if (bad++ < 10) $display("FAIL rand_cycle%0d count=%0d/%0d ack=%b%b/%b%b fw=%b/%b fr=%b/%b cv=%b/%b cd=%h/%h din=%h/%h",
                    n, count, m_q.size(), p1_ack, p0_ack, e_p1_ack, e_p0_ack, fifo_write, e_fw, fifo_read, e_fr, c_valid, e_cv, c_data, e_cd, fifo_din, e_din);
            end
            if (p0_req && e_p0_ack) begin if ($urandom_range(1) == 0) p0_req = 0; else p0_data = DW'($urandom); end
            else if (!p0_req && $urandom_range(2) == 0) begin p0_req = 1; p0_data = DW'($urandom); end
            if (p1_req && e_p1_ack) begin if ($urandom_range(1) == 0) p1_req = 0; else p1_data = DW'($urandom); end
            else if (!p1_req && $urandom_range(2) == 0) begin p1_req = 1; p1_data = DW'($urandom); end
        end
        p0_req = 0; p1_req = 0; c_req = 0; reset = 1;
    endtask

    initial begin
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full();
        test_empty_bypass();
        test_reset_midflight();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
